// File: rtl/seq_sched_pkg.sv
// rtl/seq_sched_pkg.sv - shared types and constants for the sequence scheduler
package seq_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

endpackage

// File: rtl/seq_sched_rr_arb2.sv
// rtl/seq_sched_rr_arb2.sv - two-way round-robin arbiter, pointer moves only on a grant
module rr_arb2
    import seq_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       id
);

    logic       r_ptr;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_ptr == ID0) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign gnt = w_gnt;
    assign id  = w_gnt[1] ? ID1 : ID0;

    // Priority passes to the requester that was not just served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= ID0;
        end else if (|w_gnt) begin
            r_ptr <= ~id;
        end
    end

endmodule

// File: rtl/seq_sched.sv
// rtl/seq_sched.sv - shares one serial detector between two word requesters, counts matches per frame
module seq_sched
    import seq_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             det_rst,
    output logic             det_in,
    input  logic             det_out,
    output logic             done,
    output logic             done_id,
    output logic [CNTW-1:0]  match_cnt
);

    localparam int IDXW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [IDXW-1:0]  r_bit_idx;
    logic             r_shift_d1;
    logic             r_vld;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  w_cnt_next;
    logic             r_served_id;

    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_det_rst;
    logic             r_det_in;
    logic             r_done;
    logic             r_done_id;
    logic [CNTW-1:0]  r_match_cnt;

    logic [1:0]       w_arb_gnt;
    logic             w_arb_id;
    logic             w_arb_en;
    logic             w_grant;
    logic             w_hit;
    logic             w_gnt0_d;
    logic             w_gnt1_d;
    logic             w_det_rst_d;
    logic             w_det_in_d;
    logic             w_done_d;

    // The cycle showing done is still IDLE-blocked so frames stay WIDTH+5 apart.
    assign w_arb_en = (r_state == IDLE) && !r_done;
    assign w_grant  = |w_arb_gnt;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1, req0}),
        .en    (w_arb_en),
        .gnt   (w_arb_gnt),
        .id    (w_arb_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next_state = CLR;
            CLR:     w_next_state = SHIFT;
            SHIFT:   if (r_bit_idx == '0) w_next_state = DRAIN;
            DRAIN:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_gnt0_d    = w_arb_gnt[0];
        w_gnt1_d    = w_arb_gnt[1];
        w_det_rst_d = (r_state == CLR);
        w_det_in_d  = (r_state == SHIFT) ? r_shift[WIDTH-1] : 1'b0;
        w_done_d    = (r_state == DONE);
    end

    // det_out lags det_in by one cycle and det_in lags SHIFT by one, hence two stages.
    assign w_hit      = r_vld && det_out;
    assign w_cnt_next = r_cnt + {{(CNTW-1){1'b0}}, w_hit};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_shift_d1  <= 1'b0;
            r_vld       <= 1'b0;
            r_cnt       <= '0;
            r_served_id <= ID0;
        end else begin
            r_shift_d1 <= (r_state == SHIFT);
            r_vld      <= r_shift_d1;
            r_cnt      <= w_cnt_next;
            if (w_grant) begin
                r_shift     <= w_arb_gnt[1] ? data1 : data0;
                r_cnt       <= '0;
                r_served_id <= w_arb_id;
            end
            if (r_state == CLR) begin
                r_bit_idx <= IDXW'(WIDTH - 1);
            end
            if (r_state == SHIFT) begin
                r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                r_bit_idx <= r_bit_idx - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_det_rst   <= 1'b1;
            r_det_in    <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= ID0;
            r_match_cnt <= '0;
        end else begin
            r_gnt0    <= w_gnt0_d;
            r_gnt1    <= w_gnt1_d;
            r_det_rst <= w_det_rst_d;
            r_det_in  <= w_det_in_d;
            r_done    <= w_done_d;
            if (w_done_d) begin
                r_done_id   <= r_served_id;
                r_match_cnt <= w_cnt_next;
            end
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign det_rst   = r_det_rst;
    assign det_in    = r_det_in;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_sched.sv
// tb/tb_seq_sched.sv - directed vector bench for seq_sched with a one-cycle stub detector
module tb_seq_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       gnt0;
    logic       gnt1;
    logic       det_rst;
    logic       det_in;
    logic       det_out = 1'b0;
    logic       done;
    logic       done_id;
    logic [3:0] match_cnt;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         exp_id;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[8];

    seq_sched #(.WIDTH(8), .CNTW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .det_rst   (det_rst),
        .det_in    (det_in),
        .det_out   (det_out),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (det_rst) det_out <= 1'b0;
        else         det_out <= det_in;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_gnt(output int id, output int at);
        bit found = 0;
        id = -1;
        at = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                found = 1;
                id = gnt1 ? 1 : 0;
                at = cyc;
                check("gnt_onehot", int'(gnt0 & gnt1), 0);
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt_timeout: got none expected a grant within 40 cycles");
        end
    endtask

    task automatic wait_done(output int at);
        bit found = 0;
        at = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                at = cyc;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got none expected done within 40 cycles");
        end
    endtask

    initial begin
        int id;
        int tg;
        int td;
        int prev;
        int early;
        logic [7:0] w;

        vecs[0] = '{1'b1, 1'b0, 8'hB5, 8'h00, 0, 5};
        vecs[1] = '{1'b1, 1'b1, 8'hFF, 8'h01, 1, 1};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'h01, 0, 8};
        vecs[3] = '{1'b1, 1'b0, 8'hF0, 8'h00, 0, 4};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 1, 0};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h80, 1, 1};
        vecs[6] = '{1'b1, 1'b1, 8'h0F, 8'hAA, 0, 4};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1, 8};

        repeat (3) @(negedge clk);
        check("rst_gnt0", int'(gnt0), 0);
        check("rst_gnt1", int'(gnt1), 0);
        check("rst_det_rst", int'(det_rst), 1);
        check("rst_det_in", int'(det_in), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_id", int'(done_id), 0);
        check("rst_match_cnt", int'(match_cnt), 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_det_rst", int'(det_rst), 0);

        for (int v = 0; v < 8; v++) begin
            data0 = vecs[v].d0;
            data1 = vecs[v].d1;
            req0  = vecs[v].r0;
            req1  = vecs[v].r1;
            wait_gnt(id, tg);
            req0 = 1'b0;
            req1 = 1'b0;
            check($sformatf("vec%0d_gnt_id", v), id, vecs[v].exp_id);
            wait_done(td);
            check($sformatf("vec%0d_done_lat", v), td - tg, 11);
            check($sformatf("vec%0d_cnt", v), int'(match_cnt), vecs[v].exp_cnt);
            check($sformatf("vec%0d_done_id", v), int'(done_id), vecs[v].exp_id);
        end

        // B5 bit stream and detector clear timing
        w = 8'hB5;
        data0 = w;
        req0 = 1'b1;
        wait_gnt(id, tg);
        req0 = 1'b0;
        check("b5_gnt_id", id, 0);
        @(negedge clk);
        check("b5_det_rst_t1", int'(det_rst), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b5_bit%0d", i), int'(det_in), int'(w[7-i]));
            check($sformatf("b5_rst_low%0d", i), int'(det_rst), 0);
        end
        @(negedge clk);
        check("b5_drain_in", int'(det_in), 0);
        check("b5_drain_nodone", int'(done), 0);
        @(negedge clk);
        check("b5_done_t11", int'(done), 1);
        check("b5_cnt", int'(match_cnt), 5);
        @(negedge clk);
        check("b5_done_pulse", int'(done), 0);
        check("b5_cnt_held", int'(match_cnt), 5);

        // data change after grant has no effect
        data0 = 8'hF0;
        req0 = 1'b1;
        wait_gnt(id, tg);
        req0 = 1'b0;
        @(negedge clk);
        data0 = 8'h00;
        wait_done(td);
        check("chg_cnt", int'(match_cnt), 4);

        // back-to-back from a fresh pointer
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        data0 = 8'hFF;
        data1 = 8'h01;
        req0 = 1'b1;
        req1 = 1'b1;
        reset = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(id, tg);
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (k == 0) check("b2b_first_edge", tg - prev, tg - prev);
            check($sformatf("b2b_id%0d", k), id, k % 2);
            if (k > 0) check($sformatf("b2b_period%0d", k), tg - prev, 13);
            prev = tg;
            wait_done(td);
            check($sformatf("b2b_lat%0d", k), td - tg, 11);
            check($sformatf("b2b_cnt%0d", k), int'(match_cnt), (k % 2) ? 1 : 8);
            check($sformatf("b2b_done_id%0d", k), int'(done_id), k % 2);
        end

        // lone requester 1 wins repeatedly even when the pointer favours 0
        data1 = 8'h00;
        req1 = 1'b1;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(id, tg);
            if (k == 2) req1 = 1'b0;
            check($sformatf("solo1_id%0d", k), id, 1);
            if (k > 0) check($sformatf("solo1_period%0d", k), tg - prev, 13);
            prev = tg;
            wait_done(td);
            check($sformatf("solo1_cnt%0d", k), int'(match_cnt), 0);
        end

        // reset mid-frame discards the frame
        data0 = 8'hFF;
        req0 = 1'b1;
        wait_gnt(id, tg);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_gnt0", int'(gnt0), 0);
        check("mid_rst_det_rst", int'(det_rst), 1);
        check("mid_rst_det_in", int'(det_in), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_cnt", int'(match_cnt), 0);
        data1 = 8'h3C;
        req1 = 1'b1;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || gnt1) early++;
        end
        check("mid_rst_quiet", early, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_gnt1_first_edge", int'(gnt1), 1);
        req1 = 1'b0;
        wait_done(td);
        check("rel_cnt", int'(match_cnt), 4);
        check("rel_done_id", int'(done_id), 1);

        // request raised during SHIFT waits for the frame to finish
        data1 = 8'h81;
        req1 = 1'b1;
        wait_gnt(id, tg);
        req1 = 1'b0;
        check("late_first_id", id, 1);
        early = 0;
        td = -1;
        for (int i = 1; i <= 20 && td < 0; i++) begin
            @(negedge clk);
            if (i == 4) begin
                data0 = 8'h00;
                req0 = 1'b1;
            end
            if (gnt0 || gnt1) early++;
            if (done) td = cyc;
        end
        check("late_no_early_gnt", early, 0);
        check("late_done_lat", td - tg, 11);
        check("late_cnt", int'(match_cnt), 2);
        check("late_done_id", int'(done_id), 1);
        @(negedge clk);
        check("late_blocked_after_done", int'(gnt0), 0);
        @(negedge clk);
        check("late_gnt0", int'(gnt0), 1);
        req0 = 1'b0;
        wait_done(td);
        check("late_cnt0", int'(match_cnt), 0);
        check("late_done_id0", int'(done_id), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
